pwm_peripheral: RTL and testbench



---
 rtl/pwm_peripheral_if.sv | 30 +++
 rtl/pwm_peripheral.sv | 108 ++++++++++
 tb/tb_pwm_peripheral.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_peripheral_if.sv
// rtl/pwm_peripheral_if.sv - register-side bundle between the SPI register block and the PWM peripheral
//
// Signals:
//   en_reg_out_7_0 / en_reg_out_15_8  per-output enable (low byte / high byte)
//   en_reg_pwm_7_0 / en_reg_pwm_15_8  per-output PWM mode select (low byte / high byte)
//   pwm_duty_cycle                    duty value, high ticks per 256-tick period
//   out                               registered user outputs
//   period_start                      one-clk pulse at the start of each PWM period
// Modports:
//   master  register-block side: drives configuration, observes outputs
//   slave   PWM peripheral side: consumes configuration, drives outputs
interface pwm_peripheral_if;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  modport master (
    output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    input  out, period_start
  );

  modport slave (
    input  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle,
    output out, period_start
  );
endinterface

// File: rtl/pwm_peripheral.sv
// rtl/pwm_peripheral.sv - 16-output PWM peripheral driven by the SPI configuration registers
//
// Each of the 16 outputs is forced low, forced high, or driven by one shared
// 8-bit PWM waveform. A free-running prescaler produces a tick every PRESCALE
// clks; the PWM counter advances on each tick, so a period is 256*PRESCALE clks.
//
// Parameters:
//   PRESCALE  clk cycles per PWM counter tick (1..65535, default 13)
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pwm_peripheral_if.slave: enable/mode/duty registers in, out/period_start out
// Build option:
//   PWM_DUTY_SHADOW_EN  when defined, the duty value is captured into a shadow
//                       register only at the 255->0 wrap so a mid-period write
//                       cannot glitch the current period; otherwise the duty
//                       input is used directly.
module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_peripheral_if.slave  bus
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt;
  logic        tick;
  logic [7:0]  pwm_cnt;
  logic        wrap;
  logic [7:0]  duty_active;
  logic        level;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [15:0] out_next;
  logic [15:0] out_q;
  logic        period_start_q;

  assign tick = (pre_cnt == PRE_MAX);
  // Last tick of the period: the counter is about to roll 255 -> 0.
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= 16'd0;
    end else if (tick) begin
      pre_cnt <= 16'd0;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'd0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Registered from the wrap, so the pulse coincides with the first cycle the
  // counter reads 0 of a new period; the post-reset period never wrapped, so
  // it gets no pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start_q <= 1'b0;
    end else begin
      period_start_q <= wrap;
    end
  end

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= 8'h00;
    end else if (wrap) begin
      duty_shadow <= bus.pwm_duty_cycle;
    end
  end

  assign duty_active = duty_shadow;
`else
  assign duty_active = bus.pwm_duty_cycle;
`endif

  // 0xFF is treated as 100% rather than 255/256 so "full on" has no notch.
  assign level = (duty_active == 8'hFF) || (pwm_cnt < duty_active);

  assign en_out   = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
  assign en_pwm   = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
  // Disabled outputs are low regardless of mode; enabled static outputs are high.
  assign out_next = en_out & (~en_pwm | {16{level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 16'h0000;
    end else begin
      out_q <= out_next;
    end
  end

  assign bus.out          = out_q;
  assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// tb/tb_pwm_peripheral.sv - self-checking bench for pwm_peripheral (PRESCALE 13 and 1)
module tb_pwm_peripheral;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_peripheral_if ifa ();
  pwm_peripheral_if ifb ();

  assign ifa.en_reg_out_7_0  = en_out[7:0];
  assign ifa.en_reg_out_15_8 = en_out[15:8];
  assign ifa.en_reg_pwm_7_0  = en_pwm[7:0];
  assign ifa.en_reg_pwm_15_8 = en_pwm[15:8];
  assign ifa.pwm_duty_cycle  = duty;
  assign ifb.en_reg_out_7_0  = en_out[7:0];
  assign ifb.en_reg_out_15_8 = en_out[15:8];
  assign ifb.en_reg_pwm_7_0  = en_pwm[7:0];
  assign ifb.en_reg_pwm_15_8 = en_pwm[15:8];
  assign ifb.pwm_duty_cycle  = duty;

  pwm_peripheral #(.PRESCALE(13)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  pwm_peripheral #(.PRESCALE(1))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct {
    string       name;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] get_out(input bit sel);
    return sel ? ifb.out : ifa.out;
  endfunction

  function automatic logic get_ps(input bit sel);
    return sel ? ifb.period_start : ifa.period_start;
  endfunction

  // Returns just after the clk edge at which period_start is seen high.
  task automatic wait_ps(input bit sel, output bit found);
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      if (get_ps(sel)) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Samples one full period, starting right after a period_start sample and
  // ending at the next one. Bits in pwm_mask must all follow out[0]; the
  // remaining bits must equal static_val. Optionally rewrites duty at sample
  // index change_at.
  task automatic run_period(input bit sel, input logic [15:0] pwm_mask,
                            input logic [15:0] static_val, input int change_at,
                            input logic [7:0] new_duty,
                            output int len, output int hi, output int rises, output int bad);
    logic [15:0] o;
    logic        prev;
    len = 0; hi = 0; rises = 0; bad = 0;
    prev = get_out(sel) [0];
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      len++;
      o = get_out(sel);
      if (o[0]) hi++;
      if (o[0] && !prev) rises++;
      prev = o[0];
      if ((o & pwm_mask) != (o[0] ? pwm_mask : 16'h0000)) bad++;
      if ((o & ~pwm_mask) != static_val) bad++;
      if (len == change_at) duty = new_duty;
      if (get_ps(sel)) break;
    end
  endtask

  initial begin
    bit   found;
    int   cnt, len, hi, rises, bad;
    logic [7:0] prev_duty;

    vecs[0] = '{"static_a5a5",    16'hA5A5, 16'h0000, 8'h00, 16'hA5A5};
    vecs[1] = '{"pwm_without_en", 16'h0000, 16'hFFFF, 8'h00, 16'h0000};
    vecs[2] = '{"all_static_hi",  16'hFFFF, 16'h0000, 8'h00, 16'hFFFF};
    vecs[3] = '{"all_pwm_duty0",  16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
    vecs[4] = '{"mix_duty0",      16'h00FF, 16'h0F0F, 8'h00, 16'h00F0};
    vecs[5] = '{"all_pwm_dutyff", 16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
    vecs[6] = '{"mix_dutyff_a",   16'h1234, 16'hFF00, 8'hFF, 16'h1234};
    vecs[7] = '{"mix_dutyff_b",   16'h5A5A, 16'h0FF0, 8'hFF, 16'h5A5A};

    rst_n = 1'b0; en_out = 16'h0000; en_pwm = 16'h0000; duty = 8'h00;
    #2;
    check("reset_out", 32'(ifa.out), 32'h0);
    check("reset_period_start", 32'(ifa.period_start), 32'h0);

    // Drive all-high, then assert reset between edges and look before any edge.
    #18 rst_n = 1'b1;
    en_out = 16'hFFFF;
    for (int k = 0; k < 100; k++) @(posedge clk);
    #1;
    check("pre_reset_out", 32'(ifa.out), 32'hFFFF);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", 32'(ifa.out), 32'h0);
    check("async_reset_ps", 32'(ifa.period_start), 32'h0);
    for (int k = 0; k < 3; k++) @(posedge clk);
    #1;
    check("reset_hold_out", 32'(ifa.out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (ifa.period_start) begin
        found = 1'b1;
        break;
      end
    end
    check("first_period_start_found", 32'(found), 32'h1);
    check("first_period_start_clks", 32'(cnt), 32'd3328);

    // Table vectors: level is constant at duty 0x00 / 0xFF.
    prev_duty = 8'h00;
    for (int i = 0; i < 8; i++) begin
      en_out = vecs[i].en_out;
      en_pwm = vecs[i].en_pwm;
      duty   = vecs[i].duty;
`ifdef PWM_DUTY_SHADOW_EN
      if (vecs[i].duty != prev_duty) begin
        wait_ps(1'b0, found);
        check({vecs[i].name, "_sync"}, 32'(found), 32'h1);
      end
`endif
      prev_duty = vecs[i].duty;
      @(posedge clk);
      #1;
      check(vecs[i].name, 32'(ifa.out), 32'(vecs[i].exp_out));
    end

    // 50% duty on bit 0 only.
    en_out = 16'h0001; en_pwm = 16'h0001; duty = 8'h80;
    wait_ps(1'b0, found);
    check("d80_sync", 32'(found), 32'h1);
    for (int p = 0; p < 2; p++) begin
      run_period(1'b0, 16'h0001, 16'h0000, -1, 8'h00, len, hi, rises, bad);
      check("d80_len", 32'(len), 32'd3328);
      check("d80_high", 32'(hi), 32'd1664);
      check("d80_rises", 32'(rises), 32'd1);
      check("d80_bad", 32'(bad), 32'd0);
    end
    wait_ps(1'b1, found);
    check("p1_sync", 32'(found), 32'h1);
    run_period(1'b1, 16'h0001, 16'h0000, -1, 8'h00, len, hi, rises, bad);
    check("p1_len", 32'(len), 32'd256);
    check("p1_high", 32'(hi), 32'd128);
    check("p1_bad", 32'(bad), 32'd0);

    // Extremes.
    duty = 8'h00;
    wait_ps(1'b0, found);
    check("d00_sync", 32'(found), 32'h1);
    for (int p = 0; p < 2; p++) begin
      run_period(1'b0, 16'h0001, 16'h0000, -1, 8'h00, len, hi, rises, bad);
      check("d00_len", 32'(len), 32'd3328);
      check("d00_high", 32'(hi), 32'd0);
      check("d00_rises", 32'(rises), 32'd0);
    end
    duty = 8'hFF;
    wait_ps(1'b0, found);
    check("dff_sync", 32'(found), 32'h1);
    for (int p = 0; p < 2; p++) begin
      run_period(1'b0, 16'h0001, 16'h0000, -1, 8'h00, len, hi, rises, bad);
      check("dff_len", 32'(len), 32'd3328);
      check("dff_high", 32'(hi), 32'd3328);
    end

    // Mixed mode: high byte static on, low byte PWM at 25%.
    en_out = 16'hFFFF; en_pwm = 16'h00FF; duty = 8'h40;
    wait_ps(1'b0, found);
    check("mix_sync", 32'(found), 32'h1);
    run_period(1'b0, 16'h00FF, 16'hFF00, -1, 8'h00, len, hi, rises, bad);
    check("mix_len", 32'(len), 32'd3328);
    check("mix_high", 32'(hi), 32'd832);
    check("mix_rises", 32'(rises), 32'd1);
    check("mix_bad", 32'(bad), 32'd0);

    // Duty 0x40 -> 0xC0 written when the counter reads 0x20 (sample 32*13).
    en_out = 16'h0001; en_pwm = 16'h0001;
    wait_ps(1'b0, found);
    check("chg_sync", 32'(found), 32'h1);
    run_period(1'b0, 16'h0001, 16'h0000, 416, 8'hC0, len, hi, rises, bad);
    check("chg_len", 32'(len), 32'd3328);
`ifdef PWM_DUTY_SHADOW_EN
    check("chg_high_cur", 32'(hi), 32'd832);
`else
    check("chg_high_cur", 32'(hi), 32'd2496);
`endif
    check("chg_rises_cur", 32'(rises), 32'd1);
    run_period(1'b0, 16'h0001, 16'h0000, -1, 8'h00, len, hi, rises, bad);
    check("chg_high_next", 32'(hi), 32'd2496);
    check("chg_bad", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
